mac_rx_fcs: RTL and testbench

Second-generation GMII receive MAC that replaces mac_rx.
- Strips the preamble and SFD, computes CRC-32 over the frame, optionally strips the 4-byte FCS, and enforces min/max frame length.
- Emits bytes on a no-backpressure AXI-Stream master; tuser=1 flags bad frames on the tlast beat.
- Sits between the RGMII/GMII PHY adapter and the RX FIFO/packet parser, all in the rx_clk domain.

---
 rtl/mac_rx_fcs.sv | 146 ++++++++++++++
 tb/tb_mac_rx_fcs.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_fcs.sv
// rtl/mac_rx_fcs.sv - GMII receive MAC with preamble/SFD strip, CRC-32 check and length policing
// Define RX_STATS_EN to build the saturating frame statistics counters.
`timescale 1ns/1ps
module mac_rx_fcs #(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter bit STRIP_FCS = 1'b1
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad_fcs,
  output logic [31:0] stat_bad_len,
  output logic [31:0] stat_bad_sfd
);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  state_t      state;
  logic [31:0] crc_q;
  logic [15:0] len_q;
  logic        er_seen;
  logic [7:0]  ln_data [5];
  logic [4:0]  ln_vld;
  logic [4:0]  ln_last;
  logic [4:0]  ln_err;

  logic hunting, in_pay, closing, overflow, len_bad, frame_bad, sfd_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign hunting   = (state == IDLE) || (state == PREAMBLE);
  assign in_pay    = (state == PAYLOAD) && gmii_rx_dv;
  assign closing   = (state == PAYLOAD) && !gmii_rx_dv;
  assign overflow  = in_pay && (len_q >= MAX_L);
  assign len_bad   = (len_q < MIN_L) || er_seen;
  assign frame_bad = len_bad || (crc_q != CRC_RESIDUE);
  assign sfd_bad   = hunting && gmii_rx_dv && (gmii_rxd != 8'h55) && (gmii_rxd != 8'hD5);

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_IDLE;
      crc_q         <= '1;
      len_q         <= '0;
      er_seen       <= 1'b0;
      for (int i = 0; i < 5; i++) ln_data[i] <= '0;
      ln_vld        <= '0;
      ln_last       <= '0;
      ln_err        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      ln_data[0] <= gmii_rxd;
      for (int i = 1; i < 5; i++) ln_data[i] <= ln_data[i-1];
      ln_vld  <= {ln_vld[3:0], in_pay && !overflow};
      ln_last <= {ln_last[3:0], 1'b0};
      ln_err  <= {ln_err[3:0], 1'b0};
      m_axis_tdata  <= ln_data[4];
      m_axis_tvalid <= ln_vld[4];
      m_axis_tlast  <= ln_vld[4] && ln_last[4];
      m_axis_tuser  <= ln_vld[4] && ln_err[4];
      // On close or truncation the oldest stripped-mode byte ends the frame and
      // the FCS bytes behind it are dropped; otherwise the newest byte is tagged.
      if (closing || overflow) begin
        if (STRIP_FCS) begin
          m_axis_tlast <= ln_vld[4];
          m_axis_tuser <= ln_vld[4] && (overflow || frame_bad);
          ln_vld       <= '0;
        end else begin
          ln_last[1] <= 1'b1;
          ln_err[1]  <= overflow || frame_bad;
        end
      end
      case (state)
        WAIT_IDLE: if (!gmii_rx_dv) state <= IDLE;
        IDLE, PREAMBLE: begin
          if (!gmii_rx_dv)              state <= IDLE;
          else if (sfd_bad)             state <= DROP;
          else if (gmii_rxd == 8'h55)   state <= PREAMBLE;
          else begin
            state   <= PAYLOAD;
            crc_q   <= '1;
            len_q   <= '0;
            er_seen <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (!gmii_rx_dv)  state <= IDLE;
          else if (overflow) state <= DROP;
          else begin
            crc_q <= crc_byte(crc_q, gmii_rxd);
            if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
            if (gmii_rx_er) er_seen <= 1'b1;
          end
        end
        DROP:    if (!gmii_rx_dv) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef RX_STATS_EN
  logic inc_good, inc_fcs, inc_len;
  assign inc_len  = overflow || (closing && len_bad);
  assign inc_fcs  = closing && !len_bad && frame_bad;
  assign inc_good = closing && !frame_bad;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good    <= '0;
      stat_bad_fcs <= '0;
      stat_bad_len <= '0;
      stat_bad_sfd <= '0;
    end else begin
      if (inc_good && stat_good    != '1) stat_good    <= stat_good + 32'd1;
      if (inc_fcs  && stat_bad_fcs != '1) stat_bad_fcs <= stat_bad_fcs + 32'd1;
      if (inc_len  && stat_bad_len != '1) stat_bad_len <= stat_bad_len + 32'd1;
      if (sfd_bad  && stat_bad_sfd != '1) stat_bad_sfd <= stat_bad_sfd + 32'd1;
    end
  end
`else
  assign stat_good    = '0;
  assign stat_bad_fcs = '0;
  assign stat_bad_len = '0;
  assign stat_bad_sfd = '0;
`endif

endmodule

// File: tb/tb_mac_rx_fcs.sv
// tb/tb_mac_rx_fcs.sv - self-checking bench for mac_rx_fcs (stripped and unstripped instances)
`timescale 1ns/1ps
module tb_mac_rx_fcs;
`ifdef RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  a_tdata, b_tdata;
  logic        a_tvalid, a_tlast, a_tuser, b_tvalid, b_tlast, b_tuser;
  logic [31:0] a_good, a_fcs, a_len, a_sfd, b_good, b_fcs, b_len, b_sfd;

  always #4 rx_clk = ~rx_clk;

  mac_rx_fcs u_a (
    .rx_clk(rx_clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
    .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .stat_good(a_good),
    .stat_bad_fcs(a_fcs), .stat_bad_len(a_len), .stat_bad_sfd(a_sfd));

  mac_rx_fcs #(.MIN_LEN(48), .MAX_LEN(100), .STRIP_FCS(1'b0)) u_b (
    .rx_clk(rx_clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .stat_good(b_good),
    .stat_bad_fcs(b_fcs), .stat_bad_len(b_len), .stat_bad_sfd(b_sfd));

  typedef logic [7:0] bq_t [$];
  typedef struct { int unsigned cyc; logic [7:0] d; logic last; logic user; } beat_t;

  beat_t       q0[$], q1[$];
  int unsigned cyc = 0;
  int          total = 0, bad = 0;
  int unsigned m_good[2], m_fcs[2], m_len[2], m_sfd[2];
  int          beats[2], base[2];
  int unsigned first_cyc, last_s0;

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c = '1;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t mk(input int n, input int seed);
    bq_t b;
    logic [31:0] f;
    int np;
    np = (n > 4) ? n - 4 : n;
    for (int i = 0; i < np; i++) b.push_back(8'((i * 7 + seed * 13) & 255));
    if (n > 4) begin
      f = crc32(b, np);
      b.push_back(f[7:0]); b.push_back(f[15:8]); b.push_back(f[23:16]); b.push_back(f[31:24]);
    end
    return b;
  endfunction

  // Expected beats for a frame whose first byte after the SFD is sampled at edge s0.
  task automatic model(input int k, input bq_t b, input bit er, input int unsigned s0, input int lim);
    int n, mn, mx, last_i;
    bit strip, fcs_ok, lbad, trunc;
    beat_t e;
    n = b.size(); strip = (k == 0);
    mn = (k == 0) ? 64 : 48;
    mx = (k == 0) ? 1518 : 100;
    trunc = n > mx;
    if (trunc) last_i = strip ? mx - 5 : mx - 1;
    else       last_i = strip ? n - 5 : n - 1;
    fcs_ok = 1'b0;
    if (n >= 4) fcs_ok = (crc32(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]});
    lbad = (n < mn) || er;
    for (int i = 0; i <= last_i; i++) begin
      if (lim < 0 || i <= lim) begin
        e.cyc = s0 + i + 5; e.d = b[i]; e.last = (i == last_i);
        e.user = trunc || lbad || !fcs_ok;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    if (lim < 0) begin
      if (trunc || lbad) m_len[k]++;
      else if (!fcs_ok)  m_fcs[k]++;
      else               m_good[k]++;
    end
  endtask

  task automatic cmp_port(input int k, input logic tv, input logic [7:0] td, input logic tl, input logic tu);
    beat_t e;
    bit have = 1'b0;
    if (k == 0) begin
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
        total++; bad++; $display("FAIL missed_beat inst=%0d want_cyc=%0d now=%0d", k, q0[0].cyc, cyc);
        void'(q0.pop_front());
      end
      if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        total++; bad++; $display("FAIL missed_beat inst=%0d want_cyc=%0d now=%0d", k, q1[0].cyc, cyc);
        void'(q1.pop_front());
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (tv === 1'b1) begin
      if (k == 0 && beats[0] == base[0]) first_cyc = cyc;
      beats[k]++;
    end
    total++;
    if (have) begin
      if (tv !== 1'b1 || td !== e.d || tl !== e.last || (e.last && tu !== e.user)) begin
        bad++;
        $display("FAIL beat inst=%0d cyc=%0d got v=%b d=%h l=%b u=%b want v=1 d=%h l=%b u=%b",
                 k, cyc, tv, td, tl, tu, e.d, e.last, e.user);
      end
    end else if (tv !== 1'b0) begin
      bad++;
      $display("FAIL unexpected_beat inst=%0d cyc=%0d got v=%b d=%h want v=0", k, cyc, tv, td);
    end
  endtask

  always @(negedge rx_clk) begin
    cmp_port(0, a_tvalid, a_tdata, a_tlast, a_tuser);
    cmp_port(1, b_tvalid, b_tdata, b_tlast, b_tuser);
  end

  task automatic put(input logic dv, input logic er, input logic [7:0] d);
    gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
    @(posedge rx_clk); #1;
  endtask

  task automatic gap(input int n);
    repeat (n) put(1'b0, 1'b0, 8'h00);
  endtask

  task automatic preamble();
    repeat (7) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
  endtask

  task automatic send(input bq_t b, input int er_idx);
    preamble();
    last_s0 = cyc + 1;
    model(0, b, er_idx >= 0, last_s0, -1);
    model(1, b, er_idx >= 0, last_s0, -1);
    foreach (b[i]) put(1'b1, (i == er_idx), b[i]);
  endtask

  task automatic mark();
    base[0] = beats[0]; base[1] = beats[1];
  endtask

  task automatic chk_beats(input string nm, input int wa, input int wb);
    chk({nm, "_beats_a"}, 32'(beats[0] - base[0]), 32'(wa));
    chk({nm, "_beats_b"}, 32'(beats[1] - base[1]), 32'(wb));
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, "_good_a"}, a_good, STATS ? m_good[0] : 0);
    chk({nm, "_fcs_a"},  a_fcs,  STATS ? m_fcs[0]  : 0);
    chk({nm, "_len_a"},  a_len,  STATS ? m_len[0]  : 0);
    chk({nm, "_sfd_a"},  a_sfd,  STATS ? m_sfd[0]  : 0);
    chk({nm, "_good_b"}, b_good, STATS ? m_good[1] : 0);
    chk({nm, "_fcs_b"},  b_fcs,  STATS ? m_fcs[1]  : 0);
    chk({nm, "_len_b"},  b_len,  STATS ? m_len[1]  : 0);
    chk({nm, "_sfd_b"},  b_sfd,  STATS ? m_sfd[1]  : 0);
  endtask

  initial begin
    bq_t f, ref9;
    rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    beats[0] = 0; beats[1] = 0; base[0] = 0; base[1] = 0;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst_tvalid_a", a_tvalid, 0); chk("rst_tdata_a", a_tdata, 0);
    chk("rst_tlast_a", a_tlast, 0);   chk("rst_tuser_b", b_tuser, 0);
    chk_stats("rst");
    rst_n = 1'b1;

    ref9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check_value", crc32(ref9, 9), 32'hCBF43926);
    gap(3);

    mark(); f = mk(64, 1); send(f, -1); gap(12);
    chk_beats("good64", 60, 64);
    chk("first_beat_latency", first_cyc - last_s0, 5);
    chk("model_good_a", m_good[0], 1);
    chk_stats("good64");

    mark(); f[10] = f[10] ^ 8'h01; send(f, -1); gap(12);
    chk_beats("badfcs", 60, 64);
    chk_stats("badfcs");

    mark(); send(mk(40, 3), -1); gap(12);
    chk_beats("len40", 36, 40);
    mark(); send(mk(3, 4), -1); gap(12);
    chk_beats("len3", 0, 3);
    chk_stats("short");

    mark(); send(mk(1600, 5), -1); gap(12);
    chk_beats("oversize", 1514, 100);
    chk_stats("oversize");

    // Bad SFD, then two frames each after a single dv-low cycle.
    mark();
    repeat (7) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hAB);
    m_sfd[0]++; m_sfd[1]++;
    for (int i = 0; i < 20; i++) put(1'b1, 1'b0, 8'(i));
    gap(1); send(mk(64, 7), -1);
    gap(1); send(mk(64, 8), 30);
    gap(12);
    chk_beats("sfd_b2b_er", 120, 128);
    chk_stats("sfd_b2b_er");
    chk("lit_good_a", a_good, STATS ? 2 : 0);
    chk("lit_len_b",  b_len,  STATS ? 4 : 0);

    // Reset in the middle of payload byte 20.
    mark(); f = mk(64, 9);
    preamble();
    last_s0 = cyc + 1;
    model(0, f, 1'b0, last_s0, 13);
    model(1, f, 1'b0, last_s0, 13);
    for (int i = 0; i < 20; i++) put(1'b1, 1'b0, f[i]);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid_a", a_tvalid, 0);
    chk("midrst_tvalid_b", b_tvalid, 0);
    for (int k = 0; k < 2; k++) begin m_good[k] = 0; m_fcs[k] = 0; m_len[k] = 0; m_sfd[k] = 0; end
    chk_stats("midrst");
    #1;
    put(1'b1, 1'b0, f[20]); put(1'b1, 1'b0, f[21]);
    rst_n = 1'b1;
    for (int i = 22; i < 64; i++) put(1'b1, 1'b0, f[i]);
    gap(12);
    chk_beats("midrst", 14, 14);

    mark(); send(mk(64, 10), -1); gap(12);
    chk_beats("recover", 60, 64);
    chk_stats("recover");
    chk("lit_recover_good_b", b_good, STATS ? 1 : 0);

    chk("drain_a", q0.size(), 0);
    chk("drain_b", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
